// File: rtl/weight_stream_bank_pkg.sv
// Shared definitions for the weight stream consumer: defaults, fill-side
// state encoding and a small range helper.
package weight_stream_bank_pkg;

    localparam int KERN_S_DEFAULT  = 288;
    localparam int COEFF_W_DEFAULT = 16;

    // Fill-side state: FILL while the write bank is free, STALL while it is
    // still held by the engine.
    localparam logic [0:0] FILL  = 1'b0;
    localparam logic [0:0] STALL = 1'b1;

    // One bit selects between the two coefficient banks.
    typedef logic bank_t;

    // True when an engine index addresses a real coefficient of the set.
    function automatic logic in_range(input logic [31:0] idx, input logic [31:0] depth);
        return idx < depth;
    endfunction

endpackage

// File: rtl/coeff_bank_ram.sv
// Simple dual-port coefficient RAM holding two kernel sets. Both ports are
// addressed by {bank, index}; the read port is registered with its own enable.
module coeff_bank_ram
    import weight_stream_bank_pkg::*;
#(
    parameter int DEPTH_HALF = KERN_S_DEFAULT,
    parameter int DATA_W     = COEFF_W_DEFAULT,
    parameter int IDX_W      = $clog2(DEPTH_HALF)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W:0]    wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              re,
    input  logic [IDX_W:0]    rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int ROW_W = IDX_W + 1;

    logic [DATA_W-1:0] mem [0:2*DEPTH_HALF-1];

    // Bank 1 sits directly after bank 0 so the array is exactly two sets deep,
    // even when the set size is not a power of two.
    function automatic logic [ROW_W-1:0] to_row(input logic [IDX_W:0] a);
        logic [ROW_W-1:0] base;
        base = a[IDX_W] ? ROW_W'(DEPTH_HALF) : '0;
        return {1'b0, a[IDX_W-1:0]} + base;
    endfunction

    // Write port: one coefficient per popped stream word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[to_row(wr_addr)] <= wr_data;
        end
    end

    // Registered read port: output holds while re is low.
    always_ff @(posedge clk) begin
        if (re) begin
            rd_data <= mem[to_row(rd_addr)];
        end
    end

endmodule

// File: rtl/weight_stream_bank.sv
// Consumer end of a per-layer weight stream. Kernel sets are popped from a
// first-word-fall-through stream into one bank of a ping-pong buffer while the
// conv engine reads the other bank through a ROM-style port.
module weight_stream_bank
    import weight_stream_bank_pkg::*;
#(
    parameter int KERN_S  = KERN_S_DEFAULT,
    parameter int COEFF_W = COEFF_W_DEFAULT,
    parameter int ADDR_W  = $clog2(KERN_S)
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    input  logic [COEFF_W-1:0] input_V_dout,
    input  logic               input_V_empty_n,
    output logic               input_V_read,
    input  logic [ADDR_W-1:0]  weight_address,
    input  logic               weight_ce,
    output logic [COEFF_W-1:0] weight_q,
    output logic               weights_valid,
    input  logic               weights_done
);

    // Handshake: a stream word moves when input_V_empty_n and input_V_read are
    // both high in the same cycle; the word on input_V_dout is consumed then.
    // The engine samples weight_q one cycle after a weight_ce, and signals the
    // end of a set with a single-cycle weights_done while weights_valid is high.

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(KERN_S - 1);

    logic [1:0]         full;
    logic [1:0]         full_next;
    bank_t              wr_bank;
    bank_t              rd_bank;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [0:0]         fill_state;
    logic               fill_done;
    logic               release_bank;
    logic               addr_ok;
    logic               zero_q;
    logic [COEFF_W-1:0] ram_q;

    // Fill side stalls whenever the bank it would write still holds a set.
    always_comb begin
        fill_state = full[wr_bank] ? STALL : FILL;
    end

    assign input_V_read  = input_V_empty_n & (fill_state == FILL) & ~ap_rst;
    assign weights_valid = full[rd_bank] & ~ap_rst;
    assign fill_done     = input_V_read & (wr_ptr == LAST_IDX);
    assign release_bank  = weights_done & full[rd_bank];
    assign addr_ok       = in_range(32'(weight_address), 32'(KERN_S));

    // Flag update: a completing fill and a release always touch different banks.
    always_comb begin
        full_next = full;
        if (fill_done) begin
            full_next[wr_bank] = 1'b1;
        end
        if (release_bank) begin
            full_next[rd_bank] = 1'b0;
        end
    end

    // Bank flags, pointers and the registered out-of-range flag for weight_q.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_ptr  <= '0;
            zero_q  <= 1'b1;
        end else begin
            full <= full_next;
            if (input_V_read) begin
                wr_ptr <= fill_done ? '0 : wr_ptr + ADDR_W'(1);
            end
            if (fill_done) begin
                wr_bank <= ~wr_bank;
            end
            if (release_bank) begin
                rd_bank <= ~rd_bank;
            end
            if (weight_ce) begin
                zero_q <= ~addr_ok;
            end
        end
    end

    // Out-of-range reads never touch the RAM; the registered flag zeroes q.
    coeff_bank_ram #(
        .DEPTH_HALF (KERN_S),
        .DATA_W     (COEFF_W),
        .IDX_W      (ADDR_W)
    ) u_ram (
        .clk     (ap_clk),
        .we      (input_V_read),
        .wr_addr ({wr_bank, wr_ptr}),
        .wr_data (input_V_dout),
        .re      (weight_ce & addr_ok),
        .rd_addr ({rd_bank, weight_address}),
        .rd_data (ram_q)
    );

    assign weight_q = zero_q ? '0 : ram_q;

endmodule

// File: tb/tb_weight_stream_bank.sv
// Bench for weight_stream_bank: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a set-level model.
module tb_weight_stream_bank;

    localparam int KS = 4;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT (KERN_S=4) ----------------
    logic [15:0] s_dout;
    logic        s_empty_n;
    logic        input_V_read;
    logic [1:0]  w_addr;
    logic        w_ce;
    logic [15:0] weight_q;
    logic        weights_valid;
    logic        w_done;

    weight_stream_bank #(.KERN_S(KS), .COEFF_W(16), .ADDR_W(2)) dut (
        .ap_clk          (clk),
        .ap_rst          (rst),
        .input_V_dout    (s_dout),
        .input_V_empty_n (s_empty_n),
        .input_V_read    (input_V_read),
        .weight_address  (w_addr),
        .weight_ce       (w_ce),
        .weight_q        (weight_q),
        .weights_valid   (weights_valid),
        .weights_done    (w_done)
    );

    // ---------------- DUT (KERN_S=6, out-of-range addressing) ----------------
    logic [15:0] b_dout;
    logic        b_empty_n;
    logic        b_read;
    logic [2:0]  b_addr;
    logic        b_ce;
    logic [15:0] b_q;
    logic        b_valid;
    logic        b_done;

    weight_stream_bank #(.KERN_S(6), .COEFF_W(16), .ADDR_W(3)) dut6 (
        .ap_clk          (clk),
        .ap_rst          (rst),
        .input_V_dout    (b_dout),
        .input_V_empty_n (b_empty_n),
        .input_V_read    (b_read),
        .weight_address  (b_addr),
        .weight_ce       (b_ce),
        .weight_q        (b_q),
        .weights_valid   (b_valid),
        .weights_done    (b_done)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- stream source ----------------
    logic [15:0] stream_q[$];
    logic        gate;
    logic        popped_last = 1'b0;

    // Acts just after each edge: retire the word the DUT took, present the next.
    always begin
        @(posedge clk);
        #2;
        if (popped_last && stream_q.size() > 0) void'(stream_q.pop_front());
        s_empty_n = gate && (stream_q.size() > 0);
        s_dout    = (stream_q.size() > 0) ? stream_q[0] : 16'($urandom);
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic push(input int first, input int count);
        for (int i = 0; i < count; i++) stream_q.push_back(16'(first + i));
    endtask

    task automatic read_set(input string name, input int first);
        for (int i = 0; i < KS; i++) begin
            w_ce   = 1'b1;
            w_addr = 2'(i);
            step(1);
            check(name, 32'(weight_q), 32'(first + i));
        end
        w_ce = 1'b0;
    endtask

    // ---------------- scoreboard / model ----------------
    // exp_q holds the words of every complete set the engine may still use, in
    // stream order; its first KS words are the set the engine sees now.
    logic [15:0] exp_q[$];
    logic [15:0] part_q[$];
    logic [15:0] exp_rd;
    bit          q_known = 1'b0;
    bit          m_read;
    bit          m_valid;

    // Compare mid-cycle, then advance the model across the coming edge.
    always @(negedge clk) begin
        m_read  = !rst && s_empty_n && (exp_q.size() < 2 * KS);
        m_valid = !rst && (exp_q.size() >= KS);
        check("read", 32'(input_V_read), 32'(m_read));
        check("valid", 32'(weights_valid), 32'(m_valid));
        if (q_known) check("q", 32'(weight_q), 32'(exp_rd));
        if (rst) begin
            exp_q.delete();
            part_q.delete();
            exp_rd  = '0;
            q_known = 1'b1;
        end else begin
            if (w_ce) begin
                q_known = (exp_q.size() >= KS);
                if (q_known) exp_rd = exp_q[w_addr];
            end
            if (w_done && exp_q.size() >= KS) begin
                repeat (KS) void'(exp_q.pop_front());
            end
            if (m_read) begin
                part_q.push_back(s_dout);
                if (part_q.size() == KS) begin
                    foreach (part_q[i]) exp_q.push_back(part_q[i]);
                    part_q.delete();
                end
            end
        end
        popped_last = input_V_read;
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; gate = 1'b1;
        w_ce = 1'b0; w_addr = '0; w_done = 1'b0;
        s_empty_n = 1'b0; s_dout = '0;
        b_dout = '0; b_empty_n = 1'b0; b_ce = 1'b0; b_addr = '0; b_done = 1'b0;

        // Reset while the stream already has data.
        push(1, 4);
        step(1); mid();
        check("rst_read", 32'(input_V_read), 32'd0);
        check("rst_valid", 32'(weights_valid), 32'd0);
        step(2);
        rst = 1'b0;
        mid();
        check("first_pop", 32'(input_V_read), 32'd1);

        // First set 1..4 back-to-back.
        step(3); mid();
        check("valid_early", 32'(weights_valid), 32'd0);
        step(1); mid();
        check("valid_after_4th", 32'(weights_valid), 32'd1);
        step(1);
        read_set("q_set1", 1);

        // Second bank fills; the next word must wait for a release.
        push(5, 5);
        step(4); mid();
        check("stall_read", 32'(input_V_read), 32'd0);
        check("stall_valid", 32'(weights_valid), 32'd1);
        step(1);
        w_done = 1'b1;
        step(1);
        w_done = 1'b0;
        mid();
        check("resume_pop", 32'(input_V_read), 32'd1);
        step(1);
        read_set("q_set2", 5);

        // Completion of one bank coincides with release of the other.
        push(10, 4);
        step(2);
        w_done = 1'b1;
        step(1);
        w_done = 1'b0;
        mid();
        check("overlap_valid", 32'(weights_valid), 32'd1);
        check("overlap_refill", 32'(input_V_read), 32'd1);
        step(1);
        read_set("q_set3", 9);

        // Release to empty, then a done with nothing valid must be ignored.
        w_done = 1'b1;
        step(1);
        w_done = 1'b0;
        mid();
        check("valid_drained", 32'(weights_valid), 32'd0);
        step(1);
        w_done = 1'b1;
        step(1);
        w_done = 1'b0;
        mid();
        check("idle_done_valid", 32'(weights_valid), 32'd0);
        step(1);
        push(14, 3);
        step(3); mid();
        check("set4_valid", 32'(weights_valid), 32'd1);
        step(1);
        read_set("q_set4", 13);

        // Reset in the middle of a fill discards the partial set.
        w_done = 1'b1;
        step(1);
        w_done = 1'b0;
        push(17, 2);
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        mid();
        check("post_rst_valid", 32'(weights_valid), 32'd0);
        check("post_rst_q", 32'(weight_q), 32'd0);
        step(1);
        push(9, 4);
        step(4); mid();
        check("post_rst_set_valid", 32'(weights_valid), 32'd1);
        step(1);
        read_set("q_post_rst", 9);
        w_done = 1'b1;
        step(1);
        w_done = 1'b0;

        // KERN_S=6 instance: fill one set, then probe edge and out-of-range indexes.
        for (int i = 0; i < 6; i++) begin
            b_dout    = 16'(101 + i);
            b_empty_n = 1'b1;
            mid();
            check("k6_pop", 32'(b_read), 32'd1);
            step(1);
        end
        b_empty_n = 1'b0;
        mid();
        check("k6_valid", 32'(b_valid), 32'd1);
        step(1);
        b_ce = 1'b1; b_addr = 3'd5; step(1);
        check("k6_q_last", 32'(b_q), 32'd106);
        b_addr = 3'd6; step(1);
        check("k6_q_oor6", 32'(b_q), 32'd0);
        b_addr = 3'd0; step(1);
        check("k6_q_first", 32'(b_q), 32'd101);
        b_ce = 1'b0; b_addr = 3'd6; step(1);
        check("k6_q_hold", 32'(b_q), 32'd101);
        b_ce = 1'b1; b_addr = 3'd7; step(1);
        check("k6_q_oor7", 32'(b_q), 32'd0);
        b_ce = 1'b0;

        // Randomized traffic: gaps in the stream, sparse releases, rare resets.
        for (int c = 0; c < 3000; c++) begin
            gate = ($urandom_range(0, 3) != 0);
            if (stream_q.size() < 8 && $urandom_range(0, 1) == 1) stream_q.push_back(16'($urandom));
            w_ce   = ($urandom_range(0, 1) == 1);
            w_addr = 2'($urandom_range(0, 3));
            w_done = ($urandom_range(0, 5) == 0);
            rst    = ($urandom_range(0, 299) == 0);
            step(1);
        end
        rst = 1'b0; w_ce = 1'b0; w_done = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
